// File: rtl/oc_pkg.sv
// Shared definitions for the open-collector vector sequencer.
//   state_t : sequencer FSM states
//   NUM_VEC : number of input combinations swept (a,b,c -> 8)
//   RESP_W  : packed response width, two bits {y1,y0} per vector
package oc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_VEC = 8;
    localparam int RESP_W  = 16;

endpackage

// File: rtl/oc_dwell_counter.sv
// 16-bit dwell counter with synchronous clear and count enable.
//   clk, rst_n : clock / asynchronous active-low reset
//   clr        : synchronous clear (has priority over en)
//   en         : count enable
//   tc         : terminal flag, high while the count equals DWELL-1
module oc_dwell_counter #(
    parameter int DWELL = 79
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [15:0] LAST = 16'(DWELL - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 16'd1;
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/oc_vector_sequencer.sv
// Stimulus and capture sequencer for 3-input open-collector blocks.
// Sweeps {a,b,c} through 000..111, holding each vector DWELL cycles,
// samples {y1,y0} at the end of each dwell into resp, and flags pass
// when the full signature matches EXP_RESP.
//   clk, rst_n : clock / asynchronous active-low reset
//   start      : one-cycle sweep request, honoured only in IDLE
//   y0, y1     : responses of the block under stimulus
//   a, b, c    : registered stimulus (a is MSB)
//   vec_idx    : current vector, equal to {a,b,c}
//   busy       : high while sweeping
//   done       : one-cycle completion pulse
//   resp       : captured responses, bits [2i+1:2i] = {y1,y0} of vector i
//   pass       : resp == EXP_RESP, valid from the done pulse onward
module oc_vector_sequencer
    import oc_pkg::*;
#(
    parameter int                 DWELL    = 79,
    parameter logic [RESP_W-1:0]  EXP_RESP = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              y0,
    input  logic              y1,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic [2:0]        vec_idx,
    output logic              busy,
    output logic              done,
    output logic [RESP_W-1:0] resp,
    output logic              pass
);

    localparam logic [2:0] LAST_VEC = 3'(NUM_VEC - 1);

    state_t              state, state_nx;
    logic [2:0]          vec_q, vec_nx;   // doubles as the sweep index
    logic [RESP_W-1:0]   resp_nx;
    logic                pass_nx, busy_nx, done_nx;
    logic                cnt_clr, cnt_en, cnt_tc;

    oc_dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            vec_q <= '0;
            resp  <= '0;
            pass  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            vec_q <= vec_nx;
            resp  <= resp_nx;
            pass  <= pass_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        vec_nx   = vec_q;
        resp_nx  = resp;
        pass_nx  = pass;
        busy_nx  = busy;
        done_nx  = 1'b0;
        cnt_clr  = 1'b1;
        cnt_en   = 1'b0;
        case (state)
            IDLE: begin
                vec_nx = '0;
                if (start) begin
                    state_nx = DRIVE;
                    resp_nx  = '0;
                    pass_nx  = 1'b0;
                    busy_nx  = 1'b1;
                end
            end
            DRIVE: begin
                cnt_clr = 1'b0;
                cnt_en  = 1'b1;
                if (cnt_tc) begin
                    cnt_clr = 1'b1;
                    resp_nx[{vec_q, 1'b0} +: 2] = {y1, y0};
                    if (vec_q == LAST_VEC) begin
                        // Hold 111 through DONE; pass sees the last sample.
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        pass_nx  = (resp_nx == EXP_RESP);
                    end else begin
                        vec_nx = vec_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                vec_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                vec_nx   = '0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    assign {a, b, c} = vec_q;
    assign vec_idx   = vec_q;

endmodule

// File: tb/tb_oc_vector_sequencer.sv
// Directed bench for oc_vector_sequencer. Three instances:
//   u0: DWELL=4, EXP_RESP=E994   u1: DWELL=4, EXP_RESP=E995
//   u2: DWELL=2, EXP_RESP=E994
// Each is loaded with y0 = a^b^c and y1 = majority(a,b,c), whose
// hand-computed signature is 16'hE994.
module tb_oc_vector_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_s [3];
    logic        a_s [3], b_s [3], c_s [3];
    logic        y0_s [3], y1_s [3];
    logic [2:0]  vidx_s [3];
    logic        busy_s [3], done_s [3], pass_s [3];
    logic [15:0] resp_s [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_load
        assign y0_s[i] = a_s[i] ^ b_s[i] ^ c_s[i];
        assign y1_s[i] = (a_s[i] & b_s[i]) | (a_s[i] & c_s[i]) | (b_s[i] & c_s[i]);
    end

    oc_vector_sequencer #(.DWELL(4), .EXP_RESP(16'hE994)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .y0(y0_s[0]), .y1(y1_s[0]),
        .a(a_s[0]), .b(b_s[0]), .c(c_s[0]), .vec_idx(vidx_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .resp(resp_s[0]), .pass(pass_s[0]));

    oc_vector_sequencer #(.DWELL(4), .EXP_RESP(16'hE995)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .y0(y0_s[1]), .y1(y1_s[1]),
        .a(a_s[1]), .b(b_s[1]), .c(c_s[1]), .vec_idx(vidx_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .resp(resp_s[1]), .pass(pass_s[1]));

    oc_vector_sequencer #(.DWELL(2), .EXP_RESP(16'hE994)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .y0(y0_s[2]), .y1(y1_s[2]),
        .a(a_s[2]), .b(b_s[2]), .c(c_s[2]), .vec_idx(vidx_s[2]), .busy(busy_s[2]),
        .done(done_s[2]), .resp(resp_s[2]), .pass(pass_s[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] abc(input int u);
        return {a_s[u], b_s[u], c_s[u]};
    endfunction

    task automatic chk_zero(input int u, input string tag);
        chk({tag, "_abc"},  32'(abc(u)),    0);
        chk({tag, "_vidx"}, 32'(vidx_s[u]), 0);
        chk({tag, "_busy"}, 32'(busy_s[u]), 0);
        chk({tag, "_done"}, 32'(done_s[u]), 0);
        chk({tag, "_resp"}, 32'(resp_s[u]), 0);
        chk({tag, "_pass"}, 32'(pass_s[u]), 0);
    endtask

    // One full sweep from a start pulse. poke >= 0 re-asserts start for
    // one cycle in the sample window j == poke, which must be ignored.
    task automatic sweep(input int u, input int dw, input logic [15:0] er,
                         input logic ep, input int poke);
        int done_at = -1;
        int busy_n  = 0;
        start_s[u] = 1'b1;
        tick();                        // just after the start edge T (j = 0)
        for (int j = 0; j < 8 * dw + 20 && done_at < 0; j++) begin
            if (j > 0) tick();
            start_s[u] = (j == poke);
            if (j == 0) begin
                chk("clr_resp", 32'(resp_s[u]), 0);
                chk("clr_pass", 32'(pass_s[u]), 0);
            end
            if (done_s[u]) done_at = j;
            else begin
                if (busy_s[u]) busy_n++;
                if (j < 8 * dw) begin
                    chk("vec",  32'(abc(u)),    32'(j / dw));
                    chk("vidx", 32'(vidx_s[u]), 32'(j / dw));
                end
            end
        end
        start_s[u] = 1'b0;
        chk("done_lat",  32'(done_at), 32'(8 * dw));
        chk("busy_len",  32'(busy_n),  32'(8 * dw));
        chk("done_busy", 32'(busy_s[u]), 0);
        chk("done_vec",  32'(abc(u)),  7);
        chk("resp",      32'(resp_s[u]), 32'(er));
        chk("pass",      32'(pass_s[u]), 32'(ep));
        tick();
        chk("post_done", 32'(done_s[u]), 0);
        chk("post_vec",  32'(abc(u)),    0);
        chk("post_busy", 32'(busy_s[u]), 0);
        chk("hold_resp", 32'(resp_s[u]), 32'(er));
        chk("hold_pass", 32'(pass_s[u]), 32'(ep));
    endtask

    initial begin
        int found;
        int n_done;
        int d_at [2];
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) start_s[u] = 1'b0;
        tick();
        tick();
        for (int u = 0; u < 3; u++) chk_zero(u, "rst");
        rst_n = 1'b1;
        tick();

        // Basic sweep, mismatched signature, DWELL=2 corner.
        sweep(0, 4, 16'hE994, 1'b1, -1);
        sweep(1, 4, 16'hE994, 1'b0, -1);
        sweep(2, 2, 16'hE994, 1'b1, -1);

        // Stray start during vector 3 is ignored.
        sweep(0, 4, 16'hE994, 1'b1, 3 * 4 + 1);

        // Reset mid-sweep at vector 5, then a fresh sweep.
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            tick();
            if (abc(0) == 3'd5) found = 1;
        end
        chk("reach_v5", 32'(found), 1);
        chk("v5_busy",  32'(busy_s[0]), 1);
        rst_n = 1'b0;
        #1;
        chk_zero(0, "abort");
        tick();
        rst_n = 1'b1;
        tick();
        sweep(0, 4, 16'hE994, 1'b1, -1);

        // start held for 80 cycles: done at j=32 and j=66, one IDLE cycle between.
        n_done = 0;
        d_at[0] = -1;
        d_at[1] = -1;
        start_s[0] = 1'b1;
        tick();
        for (int j = 0; j < 80; j++) begin
            if (j > 0) tick();
            if (done_s[0]) begin
                if (n_done < 2) d_at[n_done] = j;
                n_done++;
            end
            if (j == 33) chk("b2b_idle", 32'(busy_s[0]), 0);
            if (j == 34) begin
                chk("b2b_busy", 32'(busy_s[0]), 1);
                chk("b2b_clr",  32'(resp_s[0]), 0);
            end
        end
        start_s[0] = 1'b0;
        chk("b2b_ndone", 32'(n_done), 2);
        chk("b2b_d0",    32'(d_at[0]), 32);
        chk("b2b_d1",    32'(d_at[1]), 66);
        // Let the third sweep (launched while start was still high) finish.
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            tick();
            if (done_s[0]) found = 1;
        end
        chk("b2b_tail", 32'(found), 1);
        chk("b2b_resp", 32'(resp_s[0]), 32'h0000E994);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/oc_vector_sequencer.md
Name: oc_vector_sequencer

Overview:
Upstream stimulus and capture stage for the 3-input open-collector function blocks (the y0/y1 evaluators). It drives a, b and c through all eight input combinations, from 000 to 111. Each vector is held for a programmable dwell time, and the block samples y0/y1 at the end of each dwell. The eight samples are packed into a 16-bit response word and compared against an expected signature. This replaces the hand-written delay testbenches with a synthesizable, self-checking sequencer.

Parameters:
- DWELL, 79, clock cycles each vector is held; legal range 2..65535.
- EXP_RESP, 16'h0000, expected response signature used for the pass flag.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to run one sweep; ignored unless in IDLE.
- y0  input  1  y0 output of the downstream OC block.
- y1  input  1  y1 output of the downstream OC block.
- a  output  1  stimulus MSB; registered.
- b  output  1  stimulus middle bit; registered.
- c  output  1  stimulus LSB; registered.
- vec_idx  output  3  current vector index, equal to {a,b,c}.
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse when the sweep completes.
- resp  output  16  captured responses; bits [2i+1:2i] = {y1,y0} for vector i.
- pass  output  1  resp == EXP_RESP; valid from the done pulse onward.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, and all of the following are 0: a, b, c, vec_idx, busy, done, resp, pass, and the dwell counter (16 bits).
- States:
  - IDLE: a, b, c = 000; busy=0; resp and pass hold the last result. start=1 moves to DRIVE on the next edge; on that edge idx=0, cnt=0, resp=0, pass=0, busy=1.
  - DRIVE: {a,b,c}=idx; cnt increments every cycle. When cnt==DWELL-1:
    - resp[2*idx+:2] <= {y1,y0}, sampled at that edge.
    - If idx==7, go to DONE.
    - Otherwise idx<=idx+1 and cnt<=0.
    - Each vector is therefore held exactly DWELL cycles, and y is sampled DWELL-1 cycles after the vector is applied.
  - DONE: one cycle. done=1, busy=0, a, b, c = 111 still held. pass is computed from the final resp and registered at the DONE edge. Next state is IDLE, and a, b, c return to 000.
- Latency: start seen at edge T gives done high in cycle T+1+8*DWELL; a full sweep is 8*DWELL cycles in DRIVE.
- start while busy or in DONE: ignored, with no queuing.
- start held high continuously: a new sweep begins on the first IDLE cycle after DONE.
- rst_n asserted mid-sweep: immediate abort to reset values; partial resp is discarded (cleared).
- idx wrap: never wraps; the sweep terminates at 7.
- The y inputs are treated as synchronous to clk, because they are combinational functions of this block's own registered outputs. No synchronizer is used.
- The counter compare uses the full 16-bit width; no overflow is possible in the legal DWELL range.

Decomposition:
- Shared package oc_pkg holds:
  - state enum {IDLE, DRIVE, DONE};
  - constant NUM_VEC=8;
  - constant RESP_W=16.
- One natural sub-module, oc_dwell_counter. It is a 16-bit counter with clear and enable inputs and a terminal flag at DWELL-1. It is instantiated once. All other logic is the FSM and capture register in the top module.

Test Plan:
All scenarios use DWELL=4. The bench ties y0 = a^b^c and y1 = majority(a,b,c), and sets EXP_RESP=16'hE994.
- Reset, then a start pulse: {a,b,c} steps 000..111, each held 4 cycles. done pulses 33 cycles after the start edge. resp=16'hE994, pass=1, busy high for exactly 32 cycles.
- Same sweep with EXP_RESP=16'hE995: resp=16'hE994, pass=0 after done.
- start pulsed again at vector 3 mid-sweep: ignored. The sweep timing and resp are identical to the first scenario.
- rst_n dropped for 1 cycle at vector 5: a, b, c, resp, busy and pass all go to 0 immediately. A fresh start afterwards yields 16'hE994 again.
- start held high for 80 cycles: two back-to-back sweeps separated by exactly one IDLE cycle after DONE. done pulses twice and resp is cleared at each sweep start.
- DWELL=2 corner: each vector is held 2 cycles, done arrives at T+17, resp=16'hE994.
